// File: rtl/alu_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_param: sequential ALU; single-cycle logic/add/sub ops plus an |
// | optional BITSIZE-cycle shift-add MUL built when ALU_SEQ_MUL_EN is set.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_seq_param #(
  parameter int BITSIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  input  logic [3:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [BITSIZE-1:0] Y,
  output logic [15:0]        flags
);

  localparam int MSB = BITSIZE - 1;

  localparam logic [3:0] OP_XOR  = 4'b0000;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ADDC = 4'b0110;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [1:0] MUL_RUN = 2'd1;
  localparam int         CW      = $clog2(BITSIZE);

  logic [2*BITSIZE-1:0] acc;
  logic [2*BITSIZE-1:0] mcand;
  logic [2*BITSIZE-1:0] prod_fin;
  logic [BITSIZE-1:0]   mplier;
  logic [CW-1:0]        cnt;
  logic                 last_iter;
`endif

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               accept;
  logic [BITSIZE:0]   sum;
  logic [BITSIZE-1:0] diff;
  logic [BITSIZE-1:0] y_op;
  logic [15:0]        flags_op;
  logic               c_op;
  logic               l_op;
  logic               o_op;
  logic               legal;

  function automatic logic [15:0] pack_flags(input logic c, input logic l, input logic o,
                                              input logic z, input logic n);
    return {8'h00, n, z, o, 2'b00, l, 1'b0, c};
  endfunction

  // DONE behaves like IDLE for acceptance, giving one single-cycle op per clock.
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef ALU_SEQ_MUL_EN
          state_nxt = (sel == OP_MUL) ? MUL_RUN : DONE;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL_RUN: if (last_iter) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
`ifdef ALU_SEQ_MUL_EN
    busy = (state == MUL_RUN);
`else
    busy = 1'b0;
`endif
  end

  // Carry-in is the stored C flag as it stands at the accepting edge.
  assign sum  = {1'b0, A} + {1'b0, B} + {{BITSIZE{1'b0}}, (sel == OP_ADDC) & flags[0]};
  assign diff = A - B;

  always_comb begin
    y_op  = '0;
    c_op  = 1'b0;
    l_op  = 1'b0;
    o_op  = 1'b0;
    legal = 1'b1;
    case (sel)
      OP_XOR:  y_op = A ^ B;
      OP_XNOR: y_op = ~(A ^ B);
      OP_AND:  y_op = A & B;
      OP_OR:   y_op = A | B;
      OP_NOT:  y_op = ~A;
      OP_ADD, OP_ADDC: begin
        y_op = sum[MSB:0];
        c_op = sum[BITSIZE];
        o_op = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        y_op = diff;
        l_op = (A < B);
        o_op = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      default: legal = 1'b0;
    endcase
    flags_op = legal ? pack_flags(c_op, l_op, o_op, (y_op == '0), y_op[MSB]) : 16'h0000;
  end

`ifdef ALU_SEQ_MUL_EN
  assign prod_fin  = acc + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == CW'(MSB));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      Y     <= '0;
      flags <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      if (accept) begin
`ifdef ALU_SEQ_MUL_EN
        if (sel == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{BITSIZE{1'b0}}, A};
          mplier <= B;
          cnt    <= '0;
        end else
`endif
        begin
          Y     <= y_op;
          flags <= flags_op;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == MUL_RUN) begin
        acc    <= prod_fin;
        mcand  <= {mcand[2*BITSIZE-2:0], 1'b0};
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_iter) begin
          Y     <= prod_fin[MSB:0];
          flags <= pack_flags(|prod_fin[2*BITSIZE-1:BITSIZE], 1'b0, 1'b0,
                              (prod_fin[MSB:0] == '0), prod_fin[MSB]);
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// Testbench for alu_seq_param (BITSIZE=16) with a behavioural reference model.
module tb_alu_seq_param;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] Y;
  logic [15:0] flags;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_flags;

  alu_seq_param #(.BITSIZE(16)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .sel(sel),
    .busy(busy), .done(done), .Y(Y), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: {flags, Y} from plain integer arithmetic on the operation rules.
  function automatic logic [31:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic cin);
    longint ua, ub, r;
    int sa, sb, sr, ci;
    logic c, l, o, legal;
    logic [15:0] y, f;
    ua = longint'(a); ub = longint'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    ci = (s == 4'h6 && cin) ? 1 : 0;
    c = 1'b0; l = 1'b0; o = 1'b0; legal = 1'b1; y = 16'h0; r = 0; sr = 0;
    case (s)
      4'h0: y = a ^ b;
      4'h2: y = ~(a ^ b);
      4'h8: y = a & b;
      4'hA: y = a | b;
      4'h7: y = ~a;
      4'h4, 4'h6: begin
        r = ua + ub + longint'(ci);
        sr = sa + sb + ci;
        y = r[15:0];
        c = (r > 65535);
        o = (sr > 32767) || (sr < -32768);
      end
      4'h5: begin
        r = ua - ub;
        sr = sa - sb;
        y = r[15:0];
        l = (ua < ub);
        o = (sr > 32767) || (sr < -32768);
      end
      4'hC: begin
        if (MUL_EN) begin
          r = ua * ub;
          y = r[15:0];
          c = (r >= 65536);
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) return 32'h0;
    f = 16'h0;
    f[0] = c; f[2] = l; f[5] = o; f[6] = (y == 16'h0); f[7] = y[15];
    return {f, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits (bounded) for done; reports edges after the accept edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        output int edges, output int bcnt,
                        output logic [15:0] y, output logic [15:0] f);
    A = a; B = b; sel = s; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0; bcnt = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      edges++;
    end
    y = Y; f = flags;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = 16'h0; B = 16'h0; sel = 4'h0;
    tick(); tick();
    checks++; if (Y !== 16'h0) begin errors++; $display("FAIL reset_Y: got %h expected 0000", Y); end
    checks++; if (flags !== 16'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0000", flags); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    // start coincident with reset is discarded
    A = 16'h7FFF; B = 16'h7FFF; sel = 4'h4; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_start_done: got %b expected 0", done); end
    checks++; if (Y !== 16'h0) begin errors++; $display("FAIL reset_start_Y: got %h expected 0000", Y); end
    model_flags = 16'h0;
  endtask

  task automatic test_vectors();
    logic [15:0] va [6] = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'h0064, 16'hFFFF, 16'h8AD0};
    logic [15:0] vb [6] = '{16'h7FFF, 16'hAFFF, 16'h0001, 16'h07D0, 16'hFFFF, 16'h8AD0};
    logic [3:0]  vs [6] = '{4'h4, 4'h4, 4'h6, 4'h5, 4'h1, 4'h5};
    logic [15:0] vy [6] = '{16'hFFFE, 16'hAFFE, 16'h0003, 16'hF894, 16'h0000, 16'h0000};
    logic [15:0] vf [6] = '{16'h00A0, 16'h0081, 16'h0000, 16'h0084, 16'h0000, 16'h0040};
    int edges, bcnt;
    logic [15:0] y, f;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], edges, bcnt, y, f);
      checks++; if (edges !== 0) begin errors++; $display("FAIL vec%0d latency: got %0d expected 0 extra edges", i, edges); end
      checks++; if (y !== vy[i]) begin errors++; $display("FAIL vec%0d Y: got %h expected %h", i, y, vy[i]); end
      checks++; if (f !== vf[i]) begin errors++; $display("FAIL vec%0d flags: got %h expected %h", i, f, vf[i]); end
      model_flags = vf[i];
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL vec_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [4] = '{4'h1, 4'h3, 4'hC, 4'hF};
    int edges, bcnt;
    logic [15:0] y, f;
    for (int i = 0; i < 4; i++) begin
      if (codes[i] == 4'hC && MUL_EN) continue;
      run_op(16'h7FFF, 16'h7FFF, 4'h4, edges, bcnt, y, f);
      run_op(16'h1234, 16'h5678, codes[i], edges, bcnt, y, f);
      checks++; if (edges !== 0) begin errors++; $display("FAIL illegal_%h latency: got %0d expected 0", codes[i], edges); end
      checks++; if (y !== 16'h0) begin errors++; $display("FAIL illegal_%h Y: got %h expected 0000", codes[i], y); end
      checks++; if (f !== 16'h0) begin errors++; $display("FAIL illegal_%h flags: got %h expected 0000", codes[i], f); end
      model_flags = 16'h0;
    end
  endtask

  task automatic test_random();
    int edges, bcnt, exp_edges;
    logic [15:0] a, b, y, f;
    logic [3:0] s;
    logic [31:0] m;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom_range(0, 15));
      m = ref_alu(a, b, s, model_flags[0]);
      exp_edges = (MUL_EN && s == 4'hC) ? 16 : 0;
      run_op(a, b, s, edges, bcnt, y, f);
      checks++; if (edges !== exp_edges) begin errors++; $display("FAIL rnd%0d latency sel=%h: got %0d expected %0d", i, s, edges, exp_edges); end
      checks++; if (bcnt !== exp_edges) begin errors++; $display("FAIL rnd%0d busy_cycles sel=%h: got %0d expected %0d", i, s, bcnt, exp_edges); end
      checks++; if (y !== m[15:0]) begin errors++; $display("FAIL rnd%0d Y sel=%h A=%h B=%h: got %h expected %h", i, s, a, b, y, m[15:0]); end
      checks++; if (f !== m[31:16]) begin errors++; $display("FAIL rnd%0d flags sel=%h A=%h B=%h: got %h expected %h", i, s, a, b, f, m[31:16]); end
      model_flags = m[31:16];
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8] = '{4'h0, 4'h2, 4'h8, 4'hA, 4'h4, 4'h5, 4'h7, 4'h6};
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 8; i++) begin
      A = 16'($urandom); B = 16'($urandom); sel = ops[$urandom_range(0, 7)];
      if (i == 1) sel = 4'h6;
      m = ref_alu(A, B, sel, model_flags[0]);
      start = 1'b1;
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b%0d done: got %b expected 1", i, done); end
      checks++; if (Y !== m[15:0]) begin errors++; $display("FAIL b2b%0d Y: got %h expected %h", i, Y, m[15:0]); end
      checks++; if (flags !== m[31:16]) begin errors++; $display("FAIL b2b%0d flags: got %h expected %h", i, flags, m[31:16]); end
      model_flags = m[31:16];
    end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_end done: got %b expected 0", done); end
    // Results hold while idle even as the operand inputs move.
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom); B = 16'($urandom); sel = 4'($urandom);
      tick();
    end
    checks++; if (Y !== m[15:0]) begin errors++; $display("FAIL hold_Y: got %h expected %h", Y, m[15:0]); end
    checks++; if (flags !== m[31:16]) begin errors++; $display("FAIL hold_flags: got %h expected %h", flags, m[31:16]); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b expected 0", done); end
  endtask

  task automatic test_mul();
    int edges, bcnt, seen;
    logic [15:0] y, f;
    A = 16'h0100; B = 16'h0100; sel = 4'hC; start = 1'b1;
    tick();
    // Second start plus operand changes while busy must not disturb the product.
    A = 16'h0003; B = 16'h0005; sel = 4'h4;
    edges = 0; bcnt = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bcnt++;
      if (edges == 1) begin start = 1'b0; A = 16'hFFFF; B = 16'hFFFF; end
      tick();
      edges++;
    end
    start = 1'b0;
    checks++; if (edges !== 16) begin errors++; $display("FAIL mul_latency: got %0d expected 16", edges); end
    checks++; if (bcnt !== 16) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 16", bcnt); end
    checks++; if (Y !== 16'h0000) begin errors++; $display("FAIL mul_Y: got %h expected 0000", Y); end
    checks++; if (flags !== 16'h0041) begin errors++; $display("FAIL mul_flags: got %h expected 0041", flags); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_after: got done=%b busy=%b expected 0 0", done, busy); end
    model_flags = 16'h0041;

    // Reset in the middle of a multiply aborts it with no done pulse.
    run_op(16'h7FFF, 16'h7FFF, 4'h4, edges, bcnt, y, f);
    A = 16'h0003; B = 16'h0005; sel = 4'hC; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (Y !== 16'h0 || flags !== 16'h0) begin errors++; $display("FAIL mulrst_result: got Y=%h flags=%h expected 0000 0000", Y, flags); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mulrst_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mulrst_no_done: got %0d pulses expected 0", seen); end
    model_flags = 16'h0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_illegal();
    test_back_to_back();
    if (MUL_EN) test_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
